// File: rtl/new_usb_pkg.sv
// rtl/new_usb_pkg.sv - shared types, constants and helpers for the NewUSB DMA engines
package new_usb_pkg;

    localparam int unsigned AxilAddrWidth = 32;
    localparam int unsigned AxilDataWidth = 32;
    localparam int unsigned AxilStrbWidth = AxilDataWidth / 8;
    localparam int unsigned MaxStrbWidth  = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_DONE  = 3'd4
    } new_usb_dma_wr_state_e;

    typedef struct packed {
        logic [AxilAddrWidth-1:0] addr;
        logic [2:0]               prot;
    } axil_aw_t;

    typedef struct packed {
        logic [AxilDataWidth-1:0] data;
        logic [AxilStrbWidth-1:0] strb;
    } axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axil_b_t;

    typedef struct packed {
        logic [AxilAddrWidth-1:0] addr;
        logic [2:0]               prot;
    } axil_ar_t;

    typedef struct packed {
        logic [AxilDataWidth-1:0] data;
        logic [1:0]               resp;
    } axil_r_t;

    typedef struct packed {
        axil_aw_t aw;
        logic     aw_valid;
        axil_w_t  w;
        logic     w_valid;
        logic     b_ready;
        axil_ar_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axil_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axil_b_t b;
        logic    b_valid;
        logic    ar_ready;
        axil_r_t r;
        logic    r_valid;
    } axil_rsp_t;

    // Byte-enable mask for a beat: full word while at least a word remains,
    // otherwise only the low 'rem' bytes of the final partial word.
    function automatic logic [MaxStrbWidth-1:0] strb_from_rem(input int unsigned rem,
                                                              input int unsigned strb_width);
        logic [MaxStrbWidth-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        if (rem >= strb_width) begin
            strb_from_rem = {MaxStrbWidth{1'b1}} >> (MaxStrbWidth - strb_width);
        end else begin
            strb_from_rem = (one << rem) - one;
        end
    endfunction

endpackage

// File: rtl/new_usb_dma_wr.sv
// rtl/new_usb_dma_wr.sv - NewUSB write DMA: ingress FIFO words to memory over AXI-Lite
module new_usb_dma_wr
    import new_usb_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 8,
    parameter type axi_req_t = axil_req_t,
    parameter type axi_rsp_t = axil_rsp_t,
    parameter type addr_t    = logic [AddrWidth-1:0],
    parameter type data_t    = logic [DataWidth-1:0],
    parameter type tf_len_t  = logic [TFLenWidth-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AddrWidth-1:0]  dst_addr_i,
    input  logic [TFLenWidth-1:0] num_bytes_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic                  transfer_done_o,
    output logic                  transfer_err_o,
    output axi_req_t              axil_write_req_o,
    input  axi_rsp_t              axil_write_rsp_i,
    input  logic [DataWidth-1:0]  fifo_data_i,
    input  logic                  fifo_valid_i,
    output logic                  fifo_ready_o,
    output logic                  busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffsWidth = $clog2(StrbWidth);
    localparam tf_len_t     StrbBytes = TFLenWidth'(StrbWidth);
    localparam addr_t       AddrStep  = AddrWidth'(StrbWidth);

    typedef logic [StrbWidth-1:0] strb_t;

    new_usb_dma_wr_state_e state_q, state_d;
    addr_t   addr_q, addr_d;
    tf_len_t rem_q, rem_d;
    logic    err_q, err_d;
    data_t   wdata_q, wdata_d;
    strb_t   strb_q, strb_d;
    logic    aw_done_q, aw_done_d;
    logic    w_done_q, w_done_d;

    logic    aw_valid, w_valid, b_ready;
    logic    aw_hs, w_hs;
    logic    misaligned;
    tf_len_t rem_next;

    assign misaligned = (dst_addr_i[OffsWidth-1:0] != '0);
    assign busy_o     = (state_q != ST_IDLE);

    // Read channel is never used by the write engine.
    logic unused_rsp;
    assign unused_rsp = ^{axil_write_rsp_i.ar_ready, axil_write_rsp_i.r, axil_write_rsp_i.r_valid};

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state logic and handshake outputs, one beat in flight at a time.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        err_d           = err_q;
        wdata_d         = wdata_q;
        strb_d          = strb_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        req_ready_o     = 1'b0;
        fifo_ready_o    = 1'b0;
        transfer_done_o = 1'b0;
        transfer_err_o  = 1'b0;
        aw_valid        = 1'b0;
        w_valid         = 1'b0;
        b_ready         = 1'b0;
        aw_hs           = 1'b0;
        w_hs            = 1'b0;
        rem_next        = (rem_q >= StrbBytes) ? (rem_q - StrbBytes) : '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d = dst_addr_i;
                    rem_d  = num_bytes_i;
                    err_d  = 1'b0;
                    if ((num_bytes_i == '0) || misaligned) begin
                        err_d   = misaligned;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                fifo_ready_o = 1'b1;
                if (fifo_valid_i) begin
                    wdata_d = fifo_data_i;
                    strb_d  = strb_t'(strb_from_rem(32'(rem_q), StrbWidth));
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Each channel keeps valid until its own handshake, independently.
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                aw_hs    = aw_valid && axil_write_rsp_i.aw_ready;
                w_hs     = w_valid && axil_write_rsp_i.w_ready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end

            ST_RESP: begin
                b_ready = 1'b1;
                if (axil_write_rsp_i.b_valid) begin
                    // An error response is recorded but the packet is still drained.
                    if (axil_write_rsp_i.b.resp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    addr_d  = addr_q + AddrStep;
                    rem_d   = rem_next;
                    state_d = (rem_next == '0) ? ST_DONE : ST_FETCH;
                end
            end

            ST_DONE: begin
                transfer_done_o = 1'b1;
                transfer_err_o  = err_q;
                state_d         = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pack the AXI-Lite request; the read channel stays tied off.
    always_comb begin
        axil_write_req_o          = '0;
        axil_write_req_o.aw.addr  = addr_q;
        axil_write_req_o.aw.prot  = '0;
        axil_write_req_o.aw_valid = aw_valid;
        axil_write_req_o.w.data   = wdata_q;
        axil_write_req_o.w.strb   = strb_q;
        axil_write_req_o.w_valid  = w_valid;
        axil_write_req_o.b_ready  = b_ready;
    end

endmodule

// File: doc/new_usb_dma_wr.md
Name: new_usb_dma_wr

Overview:
Write-direction companion to the NewUSB read DMA. It drains received USB payload words from an ingress FIFO and writes them to system memory over an AXI-Lite write port. One request describes one contiguous memory buffer. The block sits between the NewUSB receive datapath and the AXI-Lite write join. Only one write beat is in flight at a time.

Parameters:
- DataWidth, 32, data and FIFO word width in bits; multiple of 8, at least 16.
- AddrWidth, 32, AXI-Lite address width.
- TFLenWidth, 8, transfer length width; maximum transfer is 2**TFLenWidth-1 bytes.
- axi_req_t, logic, AXI-Lite request struct (aw, w, b_ready, plus unused ar/r fields).
- axi_rsp_t, logic, AXI-Lite response struct.
- addr_t / data_t / tf_len_t, derived types; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- dst_addr_i  in  AddrWidth  buffer base address; must be word-aligned.
- num_bytes_i  in  TFLenWidth  bytes to write.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- transfer_done_o  out  1  single-cycle completion pulse.
- transfer_err_o  out  1  error qualifier; meaningful only while transfer_done_o is high.
- axil_write_req_o  out  axi_req_t  AXI-Lite write request; AR and R fields are tied to 0.
- axil_write_rsp_i  in  axi_rsp_t  AXI-Lite write response.
- fifo_data_i  in  DataWidth  ingress FIFO word; bytes are packed little-endian from byte 0.
- fifo_valid_i  in  1  FIFO word valid.
- fifo_ready_o  out  1  FIFO pop.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; all AXI valid/ready outputs 0; fifo_ready_o=0; transfer_done_o=0; transfer_err_o=0; internal registers 0.
- Reset is asynchronous. Asserting it mid-transfer aborts immediately. No further AXI or FIFO handshakes occur, and no done pulse is issued.
- FSM states: IDLE, FETCH, WRITE, RESP, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr and rem = num_bytes_i, and clear err.
  - If num_bytes_i==0, or dst_addr_i[log2(DataWidth/8)-1:0]!=0: go to DONE. For the misaligned case set err=1. In both cases there is no AXI traffic and no FIFO pop.
  - Otherwise go to FETCH.
- FETCH:
  - fifo_ready_o=1.
  - On fifo_valid_i, register the word in wdata.
  - Compute strb: all ones if rem >= StrbWidth, else (1<<rem)-1.
  - Go to WRITE.
- WRITE:
  - aw_valid and w_valid are asserted together. aw.addr = addr, aw.prot = 0, w.data = wdata, w.strb = strb.
  - Per-channel sticky flags aw_done / w_done. Each valid drops in the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to RESP once both have completed. The transition may happen in the same cycle as the last handshake.
- RESP:
  - b_ready=1.
  - On b_valid: if bresp != OKAY, set err (sticky). Then addr += StrbWidth and rem -= min(rem, StrbWidth).
  - If the new rem==0, go to DONE; else go to FETCH.
- Errors do not abort the transfer. The remaining words are still popped and written so the FIFO stays in sync with the packet boundary.
- DONE: transfer_done_o=1 and transfer_err_o=err for exactly one cycle, then IDLE.
- Latency:
  - Minimum 3 cycles per beat (FETCH, WRITE, RESP) when the FIFO and slave respond immediately.
  - Done asserts the cycle after the final B handshake.
  - Zero-length or misaligned request: done asserts the cycle after acceptance.
- Address arithmetic is AddrWidth modulo. Wrap past the top of the address space is not detected.
- Words beyond ceil(num_bytes/StrbWidth) are never popped.

Decomposition:
- Shared package new_usb_pkg holds:
  - the FSM state enum new_usb_dma_wr_state_e;
  - the AXI-Lite OKAY constant;
  - the strobe-from-remaining-bytes function.
- No sub-module. A single flat module is natural.

Test Plan:
- 8 bytes at 0x1000, FIFO words 0xA, 0xB -> writes 0x1000/0xA strb 0xF and 0x1004/0xB strb 0xF; 2 pops; done with err=0.
- 6 bytes at 0x2000 -> second write 0x2004 with strb 0x3; exactly 2 pops.
- num_bytes=0 -> done the cycle after acceptance, err=0; no AW/W; fifo_ready_o stays 0.
- dst 0x1002, 4 bytes -> done with err=1; no AXI traffic; no pop.
- Slave delays aw_ready 5 cycles while w_ready is immediate -> w_valid drops after 1 cycle, aw_valid is held stable, b_ready only rises after both; 16-byte transfer completes with correct addresses.
- First B returns SLVERR on a 12-byte transfer -> all 3 beats written, 3 pops, done with err=1. A reset asserted during beat 2 of a repeat -> outputs return to 0 immediately, no done pulse.
